// File: rtl/blk_mem_pipe_if.sv
// Bus bundle for blk_mem_pipe: clear control, write port A, read port B and read status.
// master drives requests, slave is the memory.
interface blk_mem_pipe_if #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned BYTE_WIDTH    = 8,
  parameter int unsigned ADDRESS_WIDTH = 8
);
  localparam int unsigned NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

  logic                     clear;
  logic                     busy;
  logic                     wea;
  logic [NUM_BYTES-1:0]     bea;
  logic [ADDRESS_WIDTH-1:0] addra;
  logic [DATA_WIDTH-1:0]    dina;
  logic                     reb;
  logic [ADDRESS_WIDTH-1:0] addrb;
  logic [DATA_WIDTH-1:0]    doutb;
  logic                     doutb_valid;
  logic                     parity_err;

  modport master (
    output clear, wea, bea, addra, dina, reb, addrb,
    input  busy, doutb, doutb_valid, parity_err
  );

  modport slave (
    input  clear, wea, bea, addra, dina, reb, addrb,
    output busy, doutb, doutb_valid, parity_err
  );
endinterface

// File: rtl/blk_mem_pipe.sv
// Single-clock simple-dual-port RAM with byte enables, READ_LATENCY-deep read pipeline,
// read-during-write policy and clear sequencer. Define BLK_MEM_PARITY_EN for per-lane parity.
module blk_mem_pipe #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned BYTE_WIDTH    = 8,
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned RDW_MODE      = 0
) (
  input  logic          clk,
  input  logic          rst,
  blk_mem_pipe_if.slave bus
);
  localparam int unsigned NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int unsigned DEPTH     = 2 ** ADDRESS_WIDTH;

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("blk_mem_pipe: READ_LATENCY must be in 1..4");
  end
  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $error("blk_mem_pipe: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e                   state_q;
  logic [ADDRESS_WIDTH-1:0] cnt_q;
  logic                     busy_q;

  // Clear sequencer: busy_q is high exactly while one address per cycle is zeroed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.clear) begin
            state_q <= StClear;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        StClear: begin
          if (cnt_q == {ADDRESS_WIDTH{1'b1}}) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + ADDRESS_WIDTH'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
`ifdef BLK_MEM_PARITY_EN
  logic [NUM_BYTES-1:0]  par_mem [DEPTH];
`endif

  assign wr_en = bus.wea & ~busy_q;

  always_ff @(posedge clk) begin
    if (busy_q) begin
      mem[cnt_q] <= '0;
`ifdef BLK_MEM_PARITY_EN
      par_mem[cnt_q] <= '0;
`endif
    end else if (bus.wea) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (bus.bea[i]) begin
          mem[bus.addra][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.dina[i*BYTE_WIDTH +: BYTE_WIDTH];
`ifdef BLK_MEM_PARITY_EN
          par_mem[bus.addra][i] <= ^bus.dina[i*BYTE_WIDTH +: BYTE_WIDTH];
`endif
        end
      end
    end
  end

  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rd_perr;
  logic                  rd_hit;

  assign rd_hit = (RDW_MODE == 1) && wr_en && (bus.addra == bus.addrb);

  // Array read happens in the cycle reb is sampled; the nonblocking write yields read-old.
  always_comb begin
    rd_word = mem[bus.addrb];
    if (rd_hit) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (bus.bea[i]) begin
          rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.dina[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
    if (busy_q) begin
      rd_word = '0;
    end
  end

`ifdef BLK_MEM_PARITY_EN
  logic [NUM_BYTES-1:0] rd_par;

  always_comb begin
    rd_par = par_mem[bus.addrb];
    if (rd_hit) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (bus.bea[i]) begin
          rd_par[i] = ^bus.dina[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
    if (busy_q) begin
      rd_par = '0;
    end
    rd_perr = 1'b0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      rd_perr = rd_perr | ((^rd_word[i*BYTE_WIDTH +: BYTE_WIDTH]) ^ rd_par[i]);
    end
  end
`else
  assign rd_perr = 1'b0;
`endif

  logic [DATA_WIDTH-1:0]   pipe_data_q [READ_LATENCY];
  logic [READ_LATENCY-1:0] pipe_vld_q;
  logic [READ_LATENCY-1:0] pipe_perr_q;

  // Data stages only load behind a valid, so doutb holds between results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_data_q[i] <= '0;
      end
      pipe_vld_q  <= '0;
      pipe_perr_q <= '0;
    end else begin
      pipe_vld_q[0] <= bus.reb;
      if (bus.reb) begin
        pipe_data_q[0] <= rd_word;
        pipe_perr_q[0] <= rd_perr;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        if (pipe_vld_q[i-1]) begin
          pipe_data_q[i] <= pipe_data_q[i-1];
          pipe_perr_q[i] <= pipe_perr_q[i-1];
        end
      end
    end
  end

  assign bus.doutb       = pipe_data_q[READ_LATENCY-1];
  assign bus.doutb_valid = pipe_vld_q[READ_LATENCY-1];
  assign bus.parity_err  = pipe_perr_q[READ_LATENCY-1] & pipe_vld_q[READ_LATENCY-1];
endmodule

// File: tb/tb_blk_mem_pipe.sv
// Directed bench for blk_mem_pipe: two instances (read-old and write-through) share stimulus.
module tb_blk_mem_pipe;
  localparam int unsigned DW    = 32;
  localparam int unsigned BW    = 8;
  localparam int unsigned AW    = 8;
  localparam int unsigned LAT   = 3;
  localparam int unsigned DEPTH = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  blk_mem_pipe_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDRESS_WIDTH(AW)) bus0 ();
  blk_mem_pipe_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDRESS_WIDTH(AW)) bus1 ();

  assign bus1.clear = bus0.clear;
  assign bus1.wea   = bus0.wea;
  assign bus1.bea   = bus0.bea;
  assign bus1.addra = bus0.addra;
  assign bus1.dina  = bus0.dina;
  assign bus1.reb   = bus0.reb;
  assign bus1.addrb = bus0.addrb;

  blk_mem_pipe #(
    .DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDRESS_WIDTH(AW), .READ_LATENCY(LAT), .RDW_MODE(0)
  ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  blk_mem_pipe #(
    .DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDRESS_WIDTH(AW), .READ_LATENCY(LAT), .RDW_MODE(1)
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int unsigned total  = 0;
  int unsigned passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pat(input logic [7:0] a);
    return {8'hA5, a, ~a, a};
  endfunction

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    bus0.wea   = 1'b1;
    bus0.addra = a;
    bus0.dina  = d;
    bus0.bea   = be;
    step();
    bus0.wea = 1'b0;
    bus0.bea = 4'h0;
  endtask

  // Called right after the edge that sampled reb.
  task automatic wait_result(input string tag, input logic [31:0] exp0, input logic [31:0] exp1,
                             input logic exp_perr);
    for (int k = 1; k < LAT; k++) begin
      chk({tag, " early vld"}, 32'(bus0.doutb_valid), 32'd0);
      step();
    end
    chk({tag, " vld"}, 32'(bus0.doutb_valid), 32'd1);
    chk({tag, " vld1"}, 32'(bus1.doutb_valid), 32'd1);
    chk({tag, " dout0"}, bus0.doutb, exp0);
    chk({tag, " dout1"}, bus1.doutb, exp1);
    chk({tag, " perr0"}, 32'(bus0.parity_err), 32'(exp_perr));
    chk({tag, " perr1"}, 32'(bus1.parity_err), 32'd0);
    step();
    chk({tag, " vld drop"}, 32'(bus0.doutb_valid), 32'd0);
    chk({tag, " dout hold"}, bus0.doutb, exp0);
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp0,
                    input logic [31:0] exp1, input logic exp_perr);
    bus0.reb   = 1'b1;
    bus0.addrb = a;
    step();
    bus0.reb = 1'b0;
    wait_result(tag, exp0, exp1, exp_perr);
  endtask

  int unsigned busy_cnt;

  initial begin
    rst        = 1'b1;
    bus0.clear = 1'b0;
    bus0.wea   = 1'b0;
    bus0.bea   = 4'h0;
    bus0.addra = 8'h00;
    bus0.dina  = 32'h0;
    bus0.reb   = 1'b0;
    bus0.addrb = 8'h00;
    step();
    step();
    chk("rst doutb", bus0.doutb, 32'h0);
    chk("rst vld", 32'(bus0.doutb_valid), 32'd0);
    chk("rst busy", 32'(bus0.busy), 32'd0);
    chk("rst perr", 32'(bus0.parity_err), 32'd0);
    rst = 1'b0;
    step();

    // Full write and latency-3 read
    wr(8'h05, 32'hDEADBEEF, 4'hF);
    rd("basic", 8'h05, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);

    // Byte-lane merge; bea=0 write is a no-op
    wr(8'h10, 32'h11223344, 4'hF);
    wr(8'h10, 32'hAABBCCDD, 4'b0101);
    wr(8'h10, 32'h00000000, 4'h0);
    rd("lanes", 8'h10, 32'h11BB33DD, 32'h11BB33DD, 1'b0);

    // Same-address read during write: full and partial lanes
    wr(8'h20, 32'h0, 4'hF);
    bus0.wea = 1'b1; bus0.addra = 8'h20; bus0.dina = 32'h55; bus0.bea = 4'hF;
    bus0.reb = 1'b1; bus0.addrb = 8'h20;
    step();
    bus0.wea = 1'b0; bus0.reb = 1'b0;
    wait_result("rdw full", 32'h0, 32'h55, 1'b0);
    wr(8'h30, 32'h11223344, 4'hF);
    bus0.wea = 1'b1; bus0.addra = 8'h30; bus0.dina = 32'hAABBCCDD; bus0.bea = 4'b0101;
    bus0.reb = 1'b1; bus0.addrb = 8'h30;
    step();
    bus0.wea = 1'b0; bus0.reb = 1'b0;
    wait_result("rdw lanes", 32'h11223344, 32'h11BB33DD, 1'b0);
    // Different addresses do not interact
    bus0.wea = 1'b1; bus0.addra = 8'h21; bus0.dina = 32'h77; bus0.bea = 4'hF;
    bus0.reb = 1'b1; bus0.addrb = 8'h20;
    step();
    bus0.wea = 1'b0; bus0.reb = 1'b0;
    wait_result("rdw diff", 32'h55, 32'h55, 1'b0);

    // Fill, then back-to-back read of the first words
    for (int a = 0; a < DEPTH; a++) wr(8'(a), pat(8'(a)), 4'hF);
    for (int i = 0; i < 8 + LAT - 1; i++) begin
      bus0.reb   = (i < 8);
      bus0.addrb = 8'(i);
      step();
      if (i >= LAT - 1) begin
        chk("b2b vld", 32'(bus0.doutb_valid), 32'd1);
        chk("b2b data", bus0.doutb, pat(8'(i - (LAT - 1))));
      end
    end
    bus0.reb = 1'b0;

    // Clear with coincident write, write and clear during busy are dropped
    chk("pre clear busy", 32'(bus0.busy), 32'd0);
    bus0.clear = 1'b1;
    bus0.wea = 1'b1; bus0.addra = 8'h40; bus0.dina = 32'h1234; bus0.bea = 4'hF;
    step();
    bus0.clear = 1'b0; bus0.wea = 1'b0;
    chk("busy rise", 32'(bus0.busy), 32'd1);
    busy_cnt = 0;
    for (int k = 0; k < 400 && bus0.busy; k++) begin
      if (k == 200) begin
        bus0.wea = 1'b1; bus0.addra = 8'h05; bus0.dina = 32'hFFFFFFFF; bus0.bea = 4'hF;
        bus0.clear = 1'b1;
      end else begin
        bus0.wea = 1'b0; bus0.clear = 1'b0;
      end
      step();
      busy_cnt++;
    end
    bus0.wea = 1'b0; bus0.clear = 1'b0;
    chk("busy cycles", busy_cnt, 32'd256);
    for (int i = 0; i < DEPTH + LAT - 1; i++) begin
      bus0.reb   = (i < DEPTH);
      bus0.addrb = 8'(i);
      step();
      if (i >= LAT - 1) begin
        chk("cleared vld", 32'(bus0.doutb_valid), 32'd1);
        chk("cleared data", bus0.doutb, 32'h0);
      end
    end
    bus0.reb = 1'b0;
    step();
    chk("post clear busy", 32'(bus0.busy), 32'd0);

    // Reset aborts a clear after addresses 0..99 are zeroed
    for (int a = 0; a < DEPTH; a++) wr(8'(a), pat(8'(a)), 4'hF);
    bus0.clear = 1'b1;
    step();
    bus0.clear = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      bus0.reb   = (k >= 98);
      bus0.addrb = 8'(k);
      step();
    end
    chk("busy read vld", 32'(bus0.doutb_valid), 32'd1);
    chk("busy read data", bus0.doutb, 32'h0);
    rst = 1'b1;
    bus0.reb = 1'b0;
    #1;
    chk("abort busy", 32'(bus0.busy), 32'd0);
    chk("abort vld", 32'(bus0.doutb_valid), 32'd0);
    chk("abort vld1", 32'(bus1.doutb_valid), 32'd0);
    chk("abort doutb", bus0.doutb, 32'h0);
    step();
    rst = 1'b0;
    step();
    rd("abort a50", 8'd50, 32'h0, 32'h0, 1'b0);
    rd("abort a99", 8'd99, 32'h0, 32'h0, 1'b0);
    rd("abort a100", 8'd100, pat(8'd100), pat(8'd100), 1'b0);
    rd("abort a200", 8'd200, pat(8'd200), pat(8'd200), 1'b0);

`ifdef BLK_MEM_PARITY_EN
    wr(8'h07, 32'h000000F0, 4'hF);
    rd("par clean", 8'h07, 32'h000000F0, 32'h000000F0, 1'b0);
    dut0.mem[7][0] = ~dut0.mem[7][0];
    rd("par flip", 8'h07, 32'h000000F1, 32'h000000F0, 1'b1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/blk_mem_pipe.md
Name: blk_mem_pipe

Overview:
Parametrised single-clock, simple-dual-port block RAM, successor to the basic write-A/read-B memory. Adds per-byte write enables, a selectable read pipeline depth with a read-valid strobe, a defined read-during-write policy and a hardware clear sequencer. Used as a line, packet or register buffer inside AXI slave cores wherever a single clock domain is enough.

Parameters:
DATA_WIDTH, 32, word width in bits; must be an integer multiple of BYTE_WIDTH.
BYTE_WIDTH, 8, width of one write-enable lane in bits.
ADDRESS_WIDTH, 8, address bits; DEPTH = 2**ADDRESS_WIDTH words.
READ_LATENCY, 1, cycles from a sampled reb to doutb_valid; legal range 1..4.
RDW_MODE, 0, same-address read-during-write policy: 0 = read-old, 1 = write-through.

Ports:
clk  input  1  single clock for both ports and the clear sequencer
rst  input  1  asynchronous, active-high reset
clear  input  1  single-cycle request to zero the whole array
busy  output  1  high while the clear sequence runs
wea  input  1  write enable
bea  input  DATA_WIDTH/BYTE_WIDTH  byte-lane enables; bit i covers dina[i*BYTE_WIDTH +: BYTE_WIDTH]
addra  input  ADDRESS_WIDTH  write address
dina  input  DATA_WIDTH  write data
reb  input  1  read enable
addrb  input  ADDRESS_WIDTH  read address
doutb  output  DATA_WIDTH  read data
doutb_valid  output  1  one-cycle strobe marking valid doutb
parity_err  output  1  parity mismatch flag, aligned with doutb_valid

Behaviour:
- Clocking: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values: doutb=0, doutb_valid=0, busy=0, parity_err=0, FSM=IDLE, clear counter=0, read pipeline valid bits cleared. Array contents are not reset.
- Write: on posedge clk with wea=1 and busy=0, only lanes with bea[i]=1 are written. Writes issued while busy=1 are dropped silently. wea=1 with bea=0 is a no-op.
- Read: reb is sampled on posedge clk and the array is read in that cycle. doutb_valid pulses exactly READ_LATENCY cycles later with the matching doutb. Back-to-back reads give one result per cycle.
- doutb holds its last value when no read result is emerging. doutb_valid is high for one cycle per accepted read.
- Read-during-write, same address, same cycle:
  - RDW_MODE=0: returns the pre-write word.
  - RDW_MODE=1: returns the merged word; enabled lanes come from dina, the others from the array.
  - Different addresses never interact.
- Reads while busy=1 are accepted and return all-zero data with doutb_valid asserted normally.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR when clear=1. busy rises on the next edge.
  - CLEAR writes zero to one address per cycle, counter 0..DEPTH-1, and ignores port A writes.
  - After the write to DEPTH-1 the FSM returns to IDLE; busy is low on the following cycle. busy is high for exactly DEPTH cycles.
  - clear asserted while busy=1 is ignored.
  - clear together with wea in IDLE: the write is performed, then the clear wipes it.
- Reset during CLEAR aborts the sequence. busy drops immediately and the array is left partially cleared; no completion is implied.
- Counter wraps are not possible: the FSM exits on the terminal count.
- An illegal READ_LATENCY or a DATA_WIDTH not divisible by BYTE_WIDTH triggers $error at elaboration in simulation builds.

Optional Feature:
BLK_MEM_PARITY_EN
- Defined: one even-parity bit is stored per byte lane, generated at write time and written as 0 by the clear sequencer (even parity of zero). On every read, parity is recomputed and compared. parity_err is asserted with doutb_valid if any lane mismatches, and is zero otherwise.
- Undefined: no parity storage; parity_err is tied to 0. Port list is identical in both builds.

Test Plan:
- Reset, then write 0xDEADBEEF to addr 0x05 with bea=4'hF, read 0x05 with READ_LATENCY=3 -> doutb_valid exactly 3 cycles after reb, doutb=0xDEADBEEF, parity_err=0.
- Write 0x11223344 to addr 0x10, then write 0xAABBCCDD with bea=4'b0101 -> a read of 0x10 returns 0x11BB33DD.
- Same-cycle write 0x55 (bea all ones) and read of addr 0x20, which holds 0x00: RDW_MODE=0 -> 0x00; RDW_MODE=1 -> 0x55.
- Fill all DEPTH=256 words, pulse clear -> busy high for exactly 256 cycles, a write during busy is lost, and every subsequent read returns 0.
- Assert rst mid-clear at count 100 -> busy=0 and doutb_valid=0 immediately; address 50 reads 0 and address 200 reads its old value.
- With BLK_MEM_PARITY_EN defined, force-flip one stored data bit via hierarchical reference at addr 0x07, then read 0x07 -> parity_err=1 coincident with doutb_valid.
